// File: rtl/trig_capture_buf.sv
// trig_capture_buf: triggered capture buffer with a double-buffered RAM.
// After an accepted trigger the writer waits for a block boundary, then
// stores rec_len+1 strobed samples into the current write bank and hands the
// finished bank to the reader (rd_ready / rd_done). Triggers that cannot be
// served while the writer is idle are counted in drop_cnt (saturating).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   d_in, stb_in             sample data and strobe
//   boundary                 block boundary; capture starts only here
//   trig                     single-cycle trigger request
//   rec_len                  last write address of a record
//   single_mode, arm         single-shot mode and its arm pulse
//   busy                     writer waiting for boundary or capturing
//   rd_ready                 a completed record is available
//   read_addr, d_out         read address / data (1-cycle latency)
//   rd_done                  release of the current read bank
//   drop_cnt                 count of refused triggers
//   ts_out                   trigger timestamp of read bank (optional)
//
// Optional feature: define TRIG_CAPTURE_BUF_TIMESTAMP_EN to add a free-running
// 32-bit counter, per-bank trigger timestamps and the ts_out port.
module trig_capture_buf #(
  parameter int unsigned dw = 16,
  parameter int unsigned aw = 6,
  parameter int unsigned cw = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [dw-1:0] d_in,
  input  logic          stb_in,
  input  logic          boundary,
  input  logic          trig,
  input  logic [aw-1:0] rec_len,
  input  logic          single_mode,
  input  logic          arm,
  output logic          busy,
  output logic          rd_ready,
  input  logic [aw-1:0] read_addr,
  output logic [dw-1:0] d_out,
  input  logic          rd_done,
  output logic [cw-1:0] drop_cnt
`ifdef TRIG_CAPTURE_BUF_TIMESTAMP_EN
  ,
  output logic [31:0]   ts_out
`endif
);

  localparam int unsigned depth = 2 ** (aw + 1);

  typedef enum logic [1:0] {W_IDLE, W_PEND, W_RUN} wstate_t;
  typedef enum logic [1:0] {B_FREE, B_FILL, B_READY} bstate_t;

  wstate_t       state, state_nxt;
  bstate_t       bank_st  [2];
  bstate_t       bank_nxt [2];
  logic [aw-1:0] waddr, waddr_nxt;
  logic [aw-1:0] len_q, len_nxt;
  logic          wbank, wbank_nxt;
  logic          rbank, rbank_nxt;
  logic          armed, armed_nxt;
  logic [cw-1:0] drop_nxt;
  logic          accept;
  logic          wr_en;
  logic [dw-1:0] mem [depth];

  // Next-state logic for writer, bank ownership, arming and drop counter.
  // Acceptance looks at the current bank state, so a bank freed by rd_done
  // in the same cycle is not yet usable.
  always_comb begin
    state_nxt = state;
    bank_nxt  = bank_st;
    waddr_nxt = waddr;
    wbank_nxt = wbank;
    rbank_nxt = rbank;
    len_nxt   = len_q;
    armed_nxt = armed;
    drop_nxt  = drop_cnt;
    wr_en     = 1'b0;
    accept    = trig && (state == W_IDLE) && (bank_st[wbank] == B_FREE) &&
                (armed || !single_mode);

    if (trig && (state == W_IDLE) && !accept && (drop_cnt != '1)) begin
      drop_nxt = drop_cnt + cw'(1);
    end

    case (state)
      W_IDLE: begin
        if (accept) begin
          state_nxt      = W_PEND;
          bank_nxt[wbank] = B_FILL;
          len_nxt        = rec_len;
        end
      end
      W_PEND: begin
        if (boundary) state_nxt = W_RUN;
      end
      W_RUN: begin
        if (stb_in) begin
          wr_en     = 1'b1;
          waddr_nxt = waddr + aw'(1);
          if (waddr == len_q) begin
            bank_nxt[wbank] = B_READY;
            wbank_nxt       = ~wbank;
            waddr_nxt       = '0;
            state_nxt       = W_IDLE;
          end
        end
      end
      default: state_nxt = W_IDLE;
    endcase

    // arm wins over the clear caused by an accepted trigger
    if (accept) armed_nxt = 1'b0;
    if (arm)    armed_nxt = 1'b1;

    // read bank is always READY (never FILLING) when released, so this never
    // collides with the completion update of the write bank
    if (rd_done && (bank_st[rbank] == B_READY)) begin
      bank_nxt[rbank] = B_FREE;
      rbank_nxt       = ~rbank;
    end
  end

  // State register; status outputs registered from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= W_IDLE;
      bank_st[0] <= B_FREE;
      bank_st[1] <= B_FREE;
      waddr      <= '0;
      len_q      <= '0;
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      armed      <= 1'b0;
      drop_cnt   <= '0;
      busy       <= 1'b0;
      rd_ready   <= 1'b0;
    end else begin
      state    <= state_nxt;
      bank_st  <= bank_nxt;
      waddr    <= waddr_nxt;
      len_q    <= len_nxt;
      wbank    <= wbank_nxt;
      rbank    <= rbank_nxt;
      armed    <= armed_nxt;
      drop_cnt <= drop_nxt;
      busy     <= (state_nxt != W_IDLE);
      rd_ready <= (bank_nxt[rbank_nxt] == B_READY);
    end
  end

  // Sample RAM write port (contents survive reset).
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[{wbank, waddr}] <= d_in;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) d_out <= '0;
    else     d_out <= mem[{rbank, read_addr}];
  end

`ifdef TRIG_CAPTURE_BUF_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_bank [2];

  // Free-running counter latched per bank at trigger acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt     <= '0;
      ts_bank[0] <= '0;
      ts_bank[1] <= '0;
      ts_out     <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'(1);
      if (accept) ts_bank[wbank] <= ts_cnt;
      ts_out <= (accept && (wbank == rbank_nxt)) ? ts_cnt : ts_bank[rbank_nxt];
    end
  end
`endif

endmodule

// File: tb/tb_trig_capture_buf.sv
// Self-checking bench for trig_capture_buf: directed scenarios followed by
// randomized traffic, all checked against a record-queue reference model.
module tb_trig_capture_buf;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int CW = 16;
  localparam int MAXLEN = 64;

  logic          clk = 1'b0;
  logic          rst, stb_in, boundary, trig, single_mode, arm, rd_done;
  logic          busy, rd_ready;
  logic [DW-1:0] d_in, d_out;
  logic [AW-1:0] rec_len, read_addr;
  logic [CW-1:0] drop_cnt;
`ifdef TRIG_CAPTURE_BUF_TIMESTAMP_EN
  logic [31:0]   ts_out;
`endif

  always #5 clk = ~clk;

  trig_capture_buf #(.dw(DW), .aw(AW), .cw(CW)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .stb_in(stb_in), .boundary(boundary),
    .trig(trig), .rec_len(rec_len), .single_mode(single_mode), .arm(arm),
    .busy(busy), .rd_ready(rd_ready), .read_addr(read_addr), .d_out(d_out),
    .rd_done(rd_done), .drop_cnt(drop_cnt)
`ifdef TRIG_CAPTURE_BUF_TIMESTAMP_EN
    , .ts_out(ts_out)
`endif
  );

  // Reference model: completed records wait in a queue in fill order; at
  // most two records (ready or in progress) exist at a time.
  typedef struct {
    int            len;
    logic [DW-1:0] s [MAXLEN];
  } rec_t;

  rec_t          done_q[$];
  rec_t          m_cur;
  int            m_phase;   // 0 no capture, 1 waiting for boundary, 2 collecting
  bit            m_armed;
  int            m_drop;
  int            m_cnt;
  bit            exp_d_chk;
  logic [DW-1:0] exp_d;
  int            nchecks = 0;
  int            nerrors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchecks++;
    assert (obs === expv) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Apply the current inputs to the model as one clock edge.
  task automatic model_step();
    int occ;
    bit acc;
    if (rst) begin
      done_q.delete();
      m_phase = 0; m_armed = 0; m_drop = 0; m_cnt = 0;
      exp_d_chk = 1; exp_d = '0;
      return;
    end
    occ = done_q.size();
    exp_d_chk = 0;
    if (occ > 0) begin
      if (int'(read_addr) < done_q[0].len) begin
        exp_d_chk = 1;
        exp_d = done_q[0].s[read_addr];
      end
    end
    acc = 0;
    if (trig && m_phase == 0) begin
      if (occ < 2 && (m_armed || !single_mode)) acc = 1;
      else if (m_drop < (1 << CW) - 1) m_drop++;
    end
    if (arm) m_armed = 1;
    else if (acc) m_armed = 0;
    if (occ > 0 && rd_done) void'(done_q.pop_front());
    case (m_phase)
      1: if (boundary) m_phase = 2;
      2: if (stb_in) begin
        m_cur.s[m_cnt] = d_in;
        m_cnt++;
        if (m_cnt == m_cur.len) begin
          done_q.push_back(m_cur);
          m_phase = 0;
        end
      end
      default: if (acc) begin
        m_phase = 1;
        m_cur.len = int'(rec_len) + 1;
        m_cnt = 0;
      end
    endcase
  endtask

  // One clock: model, edge, compare, then drop single-cycle inputs.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("rd_ready", 32'(rd_ready), 32'(done_q.size() > 0));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (exp_d_chk) chk("d_out", 32'(d_out), 32'(exp_d));
    rst = 0; trig = 0; arm = 0; rd_done = 0; boundary = 0; stb_in = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    cycle();
  endtask

  task automatic run_rec(input int first, input int n);
    boundary = 1;
    cycle();
    for (int i = 0; i < n; i++) begin
      stb_in = 1;
      d_in = DW'(first + i);
      cycle();
    end
  endtask

  task automatic capture(input int first, input int n, input int gap);
    trig = 1;
    cycle();
    repeat (gap) cycle();
    run_rec(first, n);
  endtask

  task automatic read_rec(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      read_addr = AW'(i);
      cycle();
      chk("rec_data", 32'(d_out), 32'(DW'(first + i)));
    end
  endtask

  initial begin
    rst = 0; stb_in = 0; boundary = 0; trig = 0; single_mode = 0; arm = 0;
    rd_done = 0; d_in = '0; rec_len = AW'(7); read_addr = '0;

    // basic capture: trig, boundary 3 clk later, 8 samples
    do_reset();
    chk("rst_ready", 32'(rd_ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_drop", 32'(drop_cnt), 32'(0));
    chk("rst_dout", 32'(d_out), 32'(0));
    capture(1, 8, 2);
    chk("t1_ready", 32'(rd_ready), 32'(1));
    chk("t1_busy", 32'(busy), 32'(0));
    read_rec(1, 8);
    chk("t1_drop", 32'(drop_cnt), 32'(0));
    rd_done = 1;
    cycle();
    chk("t1_released", 32'(rd_ready), 32'(0));

    // both banks full: third trigger dropped
    do_reset();
    capture(1, 8, 2);
    capture(9, 8, 2);
    trig = 1;
    cycle();
    chk("t2_drop", 32'(drop_cnt), 32'(1));
    chk("t2_busy", 32'(busy), 32'(0));
    read_rec(1, 8);
    rd_done = 1;
    cycle();
    chk("t2_ready2", 32'(rd_ready), 32'(1));
    read_rec(9, 8);
    trig = 1;
    cycle();
    chk("t2_accept", 32'(busy), 32'(1));
    run_rec(17, 8);
    rd_done = 1;
    cycle();
    read_rec(17, 8);
    rd_done = 1;
    cycle();

    // single-shot mode
    do_reset();
    single_mode = 1;
    trig = 1;
    cycle();
    chk("t3_drop1", 32'(drop_cnt), 32'(1));
    chk("t3_idle", 32'(busy), 32'(0));
    arm = 1;
    cycle();
    trig = 1;
    cycle();
    chk("t3_accept", 32'(busy), 32'(1));
    run_rec(40, 8);
    trig = 1;
    cycle();
    chk("t3_drop2", 32'(drop_cnt), 32'(2));
    chk("t3_noarm", 32'(busy), 32'(0));
    single_mode = 0;
    read_rec(40, 8);
    rd_done = 1;
    cycle();

    // boundary coincident with trigger does not start capture
    do_reset();
    rec_len = AW'(3);
    trig = 1;
    boundary = 1;
    cycle();
    chk("t4_pend", 32'(busy), 32'(1));
    for (int i = 0; i < 4; i++) begin
      stb_in = 1;
      d_in = DW'(16'hdead);
      cycle();
    end
    chk("t4_nowrite", 32'(rd_ready), 32'(0));
    run_rec(50, 4);
    chk("t4_ready", 32'(rd_ready), 32'(1));
    read_rec(50, 4);
    rd_done = 1;
    cycle();

    // rec_len changed mid-record affects only the next record
    do_reset();
    rec_len = AW'(7);
    trig = 1;
    cycle();
    boundary = 1;
    cycle();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) rec_len = AW'(3);
      stb_in = 1;
      d_in = DW'(60 + i);
      cycle();
      if (i == 3) chk("t5_not_short", 32'(rd_ready), 32'(0));
    end
    chk("t5_ready8", 32'(rd_ready), 32'(1));
    read_rec(60, 8);
    rd_done = 1;
    cycle();
    capture(70, 4, 1);
    chk("t5_ready4", 32'(rd_ready), 32'(1));
    read_rec(70, 4);
    rd_done = 1;
    cycle();
    rec_len = AW'(7);

    // reset in the middle of a record
    do_reset();
    trig = 1;
    cycle();
    boundary = 1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      stb_in = 1;
      d_in = DW'(90 + i);
      cycle();
    end
    rst = 1;
    cycle();
    chk("t6_ready", 32'(rd_ready), 32'(0));
    chk("t6_busy", 32'(busy), 32'(0));
    chk("t6_drop", 32'(drop_cnt), 32'(0));
    chk("t6_dout", 32'(d_out), 32'(0));
    capture(100, 8, 2);
    read_rec(100, 8);
    rd_done = 1;
    cycle();

    // full-bank record, then a short one reusing both banks
    rec_len = AW'(MAXLEN - 1);
    capture(200, MAXLEN, 0);
    chk("t7_full", 32'(rd_ready), 32'(1));
    read_rec(200, MAXLEN);
    rd_done = 1;
    cycle();
    rec_len = AW'(2);
    capture(300, 3, 0);
    capture(310, 3, 0);
    read_rec(300, 3);
    rd_done = 1;
    cycle();
    read_rec(310, 3);
    rd_done = 1;
    cycle();

    // randomized traffic
    for (int n = 0; n < 6000; n++) begin
      if (n % 1500 == 0) single_mode = 1'($urandom_range(0, 1));
      trig      = ($urandom_range(0, 11) == 0);
      arm       = ($urandom_range(0, 29) == 0);
      boundary  = ($urandom_range(0, 6) == 0);
      stb_in    = 1'($urandom_range(0, 1));
      d_in      = DW'($urandom);
      rec_len   = ($urandom_range(0, 7) == 0) ? AW'(MAXLEN - 1) : AW'($urandom_range(0, 12));
      read_addr = AW'($urandom_range(0, MAXLEN - 1));
      rd_done   = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 1999) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/trig_capture_buf.md
Name: trig_capture_buf

Overview:
Single-clock, parametrised triggered capture buffer. After a trigger, it records one contiguous block of strobed input samples into a double-buffered RAM and hands completed records to a local reader through a ready/done handshake. It generalises the team's fixed 64x16 decay buffer with configurable width and depth, a runtime record length, single-shot or auto-rearm modes, and a dropped-trigger count.
- Data may be dropped but must never be corrupted: every record corresponds to exactly one contiguous triggered input stream.

Parameters:
dw, 16, sample data width
aw, 6, address width per bank; maximum record length 2^aw samples
cw, 16, width of dropped-trigger counter

Ports:
clk  input  1  system clock
rst  input  1  reset
d_in  input  dw  sample data
stb_in  input  1  sample strobe
boundary  input  1  block boundary; capture starts only at a boundary
trig  input  1  single-cycle trigger request
rec_len  input  aw  last write address of a record (length = rec_len+1)
single_mode  input  1  1 = single-shot (needs arm), 0 = auto-rearm
arm  input  1  single-cycle arm pulse (single_mode only)
busy  output  1  writer in PEND or RUN
rd_ready  output  1  a completed record is available
read_addr  input  aw  reader address within the current read bank
d_out  output  dw  RAM read data, 1-cycle latency
rd_done  input  1  single-cycle release of the current read bank
drop_cnt  output  cw  saturating count of refused triggers

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset values: all banks FREE, writer IDLE, waddr=0, wbank=0, rbank=0, armed=0, busy=0, rd_ready=0, d_out=0, drop_cnt=0. RAM contents are not cleared.
- Storage: 2*2^aw x dw dual-port RAM, address {bank, addr}. Write port is driven by the writer. Read port is {rbank, read_addr}, registered, so d_out is valid 1 clk after read_addr.
- Each bank is FREE, FILLING or READY.
- Trigger acceptance requires all of: trig=1, writer IDLE, the bank at wbank FREE, and (armed or !single_mode).
- On acceptance:
  - latch rec_len into len_q; later rec_len changes do not affect the active record.
  - bank[wbank] goes to FILLING; writer goes to PEND; armed clears.
- Writer FSM:
  - IDLE -> PEND on an accepted trigger.
  - PEND -> RUN on boundary. A boundary in the same cycle as acceptance does not start RUN.
  - RUN: on stb_in, write d_in to {wbank, waddr}, then waddr+1.
  - RUN: on stb_in with waddr==len_q, the write is the last one. Then bank[wbank] goes to READY, wbank toggles, waddr returns to 0, and the writer goes to IDLE.
  - busy = (PEND or RUN).
- trig in PEND or RUN is ignored and not counted.
- trig in IDLE that is refused (no FREE bank, or single_mode with !armed) increments drop_cnt, saturating at 2^cw-1.
- arm sets armed. arm and an accepted trig in the same cycle: armed ends at 1 (arm wins).
- Reader:
  - rd_ready = (bank[rbank] == READY).
  - rd_done while rd_ready: bank[rbank] goes to FREE and rbank toggles.
  - rd_done while !rd_ready is ignored.
  - Banks are always handed out in fill order.
- Simultaneous events:
  - rd_done freeing the bank at wbank in the same cycle as trig: the trigger is refused (freeing takes effect next cycle) and counted.
  - A record completing and rd_done on the other bank in the same cycle are both applied.
- Both banks READY: the writer stays IDLE and every trigger is dropped until the reader releases a bank.
- rst mid-record: the record is discarded and all state returns to reset values next cycle.
- rec_len=0 gives a 1-sample record. rec_len=2^aw-1 fills the bank and waddr wraps to 0.

Optional Feature:
- Macro: TRIG_CAPTURE_BUF_TIMESTAMP_EN.
- With the macro: a free-running 32-bit counter (cleared by rst) is latched into a per-bank timestamp at trigger acceptance. Output ts_out[31:0] shows the timestamp of bank rbank, valid while rd_ready.
- Without the macro: no counter, no timestamp registers, and no ts_out port.

Test Plan:
- rst; auto mode, rec_len=7; trig, boundary 3 clk later, 8 stb_in with d_in=1..8 -> rd_ready=1 after the 8th strobe; read_addr 0..7 gives d_out 1..8 one clk later; busy=0; drop_cnt=0.
- Two back-to-back records (values 1..8, then 9..16) with no rd_done -> third trig dropped, drop_cnt=1; rd_done -> second record 9..16 readable; next trig accepted.
- single_mode=1, no arm: trig -> drop_cnt=1, busy=0; arm then trig -> accepted; second trig after completion, without re-arm -> drop_cnt=2.
- trig and boundary in the same cycle -> PEND only; stb_in before the next boundary writes nothing; capture starts at the next boundary.
- rec_len changed from 7 to 3 during RUN -> record still 8 samples; next record 4 samples.
- rst asserted after 4 of 8 strobes -> rd_ready=0, busy=0, drop_cnt=0; a fresh 8-sample capture reads back correctly from bank 0.
